// File: rtl/tt_scan_driver.sv
// Exhaustive stimulus driver and truth-table collector for a
// single-output combinational netlist with a fixed output latency.
module tt_scan_driver #(
    parameter int N_IN = 10,
    parameter int LAT  = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic [N_IN-1:0]   x,
    input  logic              y,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic              tt_valid,
    output logic [N_IN-1:0]   tt_idx,
    output logic              tt_bit,
    output logic [N_IN:0]     onset_count,
    output logic [15:0]       signature
);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

    localparam logic [N_IN-1:0] XMAX = '1;
    localparam logic [2:0]      LATC = 3'(LAT);

    state_t            state_q, state_d;
    logic [N_IN-1:0]   x_q, x_d;
    logic [2:0]        dcnt_q, dcnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              ab_q, ab_d;
    logic              ttv_q, ttv_d;
    logic [N_IN-1:0]   tti_q, tti_d;
    logic              ttb_q, ttb_d;
    logic [N_IN:0]     on_q, on_d;
    logic [15:0]       sig_q, sig_d;
    logic              v0_d;
    logic              flush;
    logic              begin_scan;
    logic              cap;

    // pv_q[k]/pidx_q[k]: vector applied k cycles ago; stage 0 mirrors x
    logic [LAT:0]      pv_q;
    logic [N_IN-1:0]   pidx_q [LAT+1];

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        dcnt_d     = dcnt_q;
        ab_d       = ab_q;
        v0_d       = 1'b0;
        flush      = 1'b0;
        begin_scan = 1'b0;
        unique case (state_q)
            IDLE: begin
                x_d = '0;
                if (start) begin
                    state_d    = SCAN;
                    begin_scan = 1'b1;
                end
            end
            SCAN: begin
                if (abort) begin
                    state_d = DONE;
                    flush   = 1'b1;
                    ab_d    = 1'b1;
                end else if (!pv_q[0]) begin
                    v0_d = 1'b1;
                end else if (x_q == XMAX) begin
                    state_d = DRAIN;
                    dcnt_d  = '0;
                end else begin
                    x_d  = x_q + N_IN'(1);
                    v0_d = 1'b1;
                end
            end
            DRAIN: begin
                if (abort) begin
                    state_d = DONE;
                    flush   = 1'b1;
                    ab_d    = 1'b1;
                end else if (dcnt_q == LATC) begin
                    state_d = DONE;
                end else begin
                    dcnt_d = dcnt_q + 3'd1;
                end
            end
            DONE: begin
                x_d     = '0;
                state_d = IDLE;
                if (start) begin
                    state_d    = SCAN;
                    begin_scan = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (begin_scan) begin
            x_d    = '0;
            ab_d   = 1'b0;
            dcnt_d = '0;
        end
    end

    assign cap    = pv_q[LAT] & ~flush;
    assign busy_d = (state_d == SCAN) || (state_d == DRAIN);
    assign done_d = (state_d == DONE);

    always_comb begin
        ttv_d = cap;
        tti_d = cap ? pidx_q[LAT] : tti_q;
        ttb_d = cap ? y : ttb_q;
        on_d  = on_q;
        sig_d = sig_q;
        if (begin_scan) begin
            on_d  = '0;
            sig_d = 16'hFFFF;
        end else if (cap) begin
            on_d  = on_q + {{N_IN{1'b0}}, y};
            sig_d = {sig_q[14:0], 1'b0}
                  ^ ({16{sig_q[15] ^ y}} & 16'h1021);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            x_q     <= '0;
            dcnt_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ab_q    <= 1'b0;
            ttv_q   <= 1'b0;
            tti_q   <= '0;
            ttb_q   <= 1'b0;
            on_q    <= '0;
            sig_q   <= 16'hFFFF;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            dcnt_q  <= dcnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ab_q    <= ab_d;
            ttv_q   <= ttv_d;
            tti_q   <= tti_d;
            ttb_q   <= ttb_d;
            on_q    <= on_d;
            sig_q   <= sig_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pv_q <= '0;
            for (int k = 0; k <= LAT; k++) pidx_q[k] <= '0;
        end else begin
            if (flush) begin
                pv_q <= '0;
            end else begin
                pv_q[0] <= v0_d;
                for (int k = 1; k <= LAT; k++) pv_q[k] <= pv_q[k-1];
            end
            pidx_q[0] <= x_d;
            for (int k = 1; k <= LAT; k++) pidx_q[k] <= pidx_q[k-1];
        end
    end

    assign x           = x_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign aborted     = ab_q;
    assign tt_valid    = ttv_q;
    assign tt_idx      = tti_q;
    assign tt_bit      = ttb_q;
    assign onset_count = on_q;
    assign signature   = sig_q;

endmodule

// File: tb/tb_tt_scan_driver.sv
// Bench for tt_scan_driver: a LAT=0 instance with selectable netlist
// functions and a LAT=2 instance wrapping y = x[9]&x[0] in two registers.
module tb_tt_scan_driver;

    localparam int M    = 1024;
    localparam int NONE = -1000000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        start_a = 1'b0, abort_a = 1'b0;
    logic        start_b = 1'b0, abort_b = 1'b0;
    logic [9:0]  x_a, x_b, ti_a, ti_b;
    logic        y_a, y_b;
    logic        busy_a, done_a, ab_a, tv_a, tb_a;
    logic        busy_b, done_b, ab_b, tv_b, tb_b;
    logic [10:0] on_a, on_b;
    logic [15:0] sg_a, sg_b;
    logic        r1 = 1'b0, r2 = 1'b0;
    int          fsel = 0;

    assign y_a = (fsel == 0) ? 1'b0 : (fsel == 1) ? x_a[0] : 1'b1;

    always @(posedge clk) begin
        r1 <= x_b[9] & x_b[0];
        r2 <= r1;
    end
    assign y_b = r2;

    tt_scan_driver #(.N_IN(10), .LAT(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a),
        .x(x_a), .y(y_a), .busy(busy_a), .done(done_a),
        .aborted(ab_a), .tt_valid(tv_a), .tt_idx(ti_a),
        .tt_bit(tb_a), .onset_count(on_a), .signature(sg_a)
    );

    tt_scan_driver #(.N_IN(10), .LAT(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b),
        .x(x_b), .y(y_b), .busy(busy_b), .done(done_b),
        .aborted(ab_b), .tt_valid(tv_b), .tt_idx(ti_b),
        .tt_bit(tb_b), .onset_count(on_b), .signature(sg_b)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          st_e [2] = '{NONE, NONE};
    int          ab_e [2] = '{NONE, NONE};
    int          lat  [2] = '{0, 2};
    logic [10:0] m_on [2] = '{11'd0, 11'd0};
    logic [15:0] m_sig[2] = '{16'hFFFF, 16'hFFFF};
    bit          m_abt[2] = '{1'b0, 1'b0};

    int checks = 0;
    int errors = 0;

    task automatic cmp(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h want %0h",
                     nm, cyc, act, exp);
        end
    endtask

    function automatic int fy(input int n, input int i);
        if (n == 1) return (i >> 9) & i & 1;
        if (fsel == 0) return 0;
        if (fsel == 1) return i & 1;
        return 1;
    endfunction

    function automatic logic [15:0] crc(input logic [15:0] s, input int b);
        logic fb;
        fb = s[15] ^ b[0];
        return {s[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    endfunction

    task automatic check_inst(input int n, input logic [9:0] xv,
                              input logic bz, input logic dn,
                              input logic ab, input logic tv,
                              input logic [9:0] ti, input logic tbit,
                              input logic [10:0] on,
                              input logic [15:0] sg);
        int c, e, l, dnn, i, xe, cc, yb;
        bit act, abd, ev;
        c   = cyc;
        e   = st_e[n];
        l   = lat[n];
        act = (e != NONE) && (c >= e);
        abd = (ab_e[n] != NONE);
        dnn = abd ? ab_e[n] : e + M + l + 2;
        if (act && c == e) begin
            m_on[n]  = '0;
            m_sig[n] = 16'hFFFF;
            m_abt[n] = 1'b0;
        end
        if (act && abd && c == ab_e[n]) m_abt[n] = 1'b1;
        i  = c - e - 2 - l;
        ev = act && i >= 0 && i < M && (!abd || c < ab_e[n]);
        yb = 0;
        if (ev) begin
            yb = fy(n, i);
            m_on[n]  = m_on[n] + 11'(yb);
            m_sig[n] = crc(m_sig[n], yb);
        end
        xe = 0;
        if (act && c <= dnn) begin
            cc = (abd && c >= ab_e[n]) ? ab_e[n] - 1 : c;
            xe = cc - e - 1;
            if (xe < 0) xe = 0;
            if (xe > M - 1) xe = M - 1;
        end
        cmp($sformatf("x%0d", n), 32'(xv), 32'(xe));
        cmp($sformatf("busy%0d", n), 32'(bz), 32'(act && c < dnn));
        cmp($sformatf("done%0d", n), 32'(dn), 32'(act && c == dnn));
        cmp($sformatf("aborted%0d", n), 32'(ab), 32'(m_abt[n]));
        cmp($sformatf("tt_valid%0d", n), 32'(tv), 32'(ev));
        if (ev) begin
            cmp($sformatf("tt_idx%0d", n), 32'(ti), 32'(i));
            cmp($sformatf("tt_bit%0d", n), 32'(tbit), 32'(yb));
        end
        cmp($sformatf("onset%0d", n), 32'(on), 32'(m_on[n]));
        cmp($sformatf("sig%0d", n), 32'(sg), 32'(m_sig[n]));
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            check_inst(0, x_a, busy_a, done_a, ab_a, tv_a, ti_a, tb_a,
                       on_a, sg_a);
            check_inst(1, x_b, busy_b, done_b, ab_b, tv_b, ti_b, tb_b,
                       on_b, sg_b);
        end
    end

    task automatic go(input bit a, input bit b);
        @(negedge clk);
        if (a) begin
            start_a = 1'b1;
            st_e[0] = cyc + 1;
            ab_e[0] = NONE;
        end
        if (b) begin
            start_b = 1'b1;
            st_e[1] = cyc + 1;
            ab_e[1] = NONE;
        end
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic wait_done(input int n, output int rel);
        rel = -1;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (((n == 0) ? done_a : done_b) === 1'b1) begin
                rel = cyc - st_e[n];
                return;
            end
        end
        cmp($sformatf("done_timeout%0d", n), 32'd0, 32'd1);
    endtask

    task automatic reset_checks();
        cmp("rst_x", 32'(x_a), 32'd0);
        cmp("rst_busy", 32'(busy_a), 32'd0);
        cmp("rst_done", 32'(done_a), 32'd0);
        cmp("rst_aborted", 32'(ab_a), 32'd0);
        cmp("rst_tt_valid", 32'(tv_a), 32'd0);
        cmp("rst_tt_idx", 32'(ti_a), 32'd0);
        cmp("rst_tt_bit", 32'(tb_a), 32'd0);
        cmp("rst_onset", 32'(on_a), 32'd0);
        cmp("rst_sig", 32'(sg_a), 32'hFFFF);
    endtask

    task automatic model_reset();
        for (int n = 0; n < 2; n++) begin
            st_e[n]  = NONE;
            ab_e[n]  = NONE;
            m_on[n]  = '0;
            m_sig[n] = 16'hFFFF;
            m_abt[n] = 1'b0;
        end
    endtask

    initial begin
        int r;
        repeat (2) @(negedge clk);
        reset_checks();
        #2 rst_n = 1'b1;

        // y tied 0 on A, registered x[9]&x[0] on B
        fsel = 0;
        go(1, 1);
        repeat (2) @(negedge clk);
        cmp("first_tt_valid", 32'(tv_a), 32'd1);
        cmp("first_tt_idx", 32'(ti_a), 32'd0);
        cmp("first_sig", 32'(sg_a), 32'hEFDF);
        wait_done(0, r);
        cmp("zero_latency", 32'(r), 32'd1026);
        cmp("zero_onset", 32'(on_a), 32'd0);
        wait_done(1, r);
        cmp("lat2_latency", 32'(r), 32'd1028);
        cmp("lat2_onset", 32'(on_b), 32'd256);

        fsel = 1;
        go(1, 0);
        wait_done(0, r);
        cmp("x0_latency", 32'(r), 32'd1026);
        cmp("x0_onset", 32'(on_a), 32'd512);

        // y tied 1, with a start pulse mid-scan that must be ignored
        fsel = 2;
        go(1, 0);
        repeat (300) @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        wait_done(0, r);
        cmp("one_latency", 32'(r), 32'd1026);
        cmp("one_onset", 32'(on_a), 32'd1024);

        fsel = 1;
        go(1, 0);
        repeat (101) @(negedge clk);
        cmp("abort_x", 32'(x_a), 32'd100);
        abort_a = 1'b1;
        ab_e[0] = cyc + 1;
        @(negedge clk);
        abort_a = 1'b0;
        cmp("abort_done", 32'(done_a), 32'd1);
        cmp("abort_flag", 32'(ab_a), 32'd1);
        cmp("abort_tt_valid", 32'(tv_a), 32'd0);
        cmp("abort_onset", 32'(on_a), 32'd50);
        repeat (3) @(negedge clk);

        go(1, 0);
        repeat (501) @(negedge clk);
        cmp("reset_x", 32'(x_a), 32'd500);
        #2 rst_n = 1'b0;
        model_reset();
        #1 reset_checks();
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        go(1, 0);
        wait_done(0, r);
        cmp("rerun_latency", 32'(r), 32'd1026);
        cmp("rerun_onset", 32'(on_a), 32'd512);
        cmp("rerun_aborted", 32'(ab_a), 32'd0);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
